ex_muldiv_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit for the execute stage; the successor to the ALU-ready stall path.

---
 rtl/ex_muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes toward EX and EX/MEM.
// Define MULDIV_FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU with a single-cycle multiplier; DIV/REM stay iterative.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e              state, state_nxt;
  op_e                 op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [CNT_W-1:0]    count;
  logic [2*XLEN-1:0]   acc;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]     opnd;   // |a| for multiply, |b| for divide
  logic                q_neg;  // product or quotient must be negated
  logic                r_neg;  // remainder must be negated

  // Accept-cycle decode of operand signedness and the divide special cases.
  logic            accept, is_div, signed_a, signed_b, neg_a, neg_b;
  logic            div_zero, div_ovf, direct_done;
  logic [XLEN-1:0] a_abs, b_abs;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_div      = in_op[2];
    signed_a    = is_div ? ~in_op[0] : (in_op == 3'b001 || in_op == 3'b010);
    signed_b    = is_div ? ~in_op[0] : (in_op == 3'b001);
    neg_a       = signed_a & in_a[XLEN-1];
    neg_b       = signed_b & in_b[XLEN-1];
    a_abs       = neg_a ? -in_a : in_a;
    b_abs       = neg_b ? -in_b : in_b;
    div_zero    = is_div && (in_b == '0);
    div_ovf     = is_div && ~in_op[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    direct_done = div_zero | div_ovf;
`ifdef MULDIV_FAST_MUL_EN
    direct_done = direct_done | ~is_div;
`endif
  end

  assign accept = in_valid && (state == IDLE) && !flush;

  // One shift-add or one restoring-divide step per CALC cycle.
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_trial - {1'b0, opnd};
    div_ge    = ~div_diff[XLEN];
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]), acc[XLEN-2:0], div_ge};
  end

  // Sign correction and result selection; special cases preload acc with flags cleared.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  always_comb begin
    prod_fix     = q_neg ? -acc : acc;
    quo_fix      = q_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix      = r_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    final_result = prod_fix[XLEN-1:0];
    case (op_q)
      OP_MUL:                       final_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_result = quo_fix;
      OP_REM, OP_REMU:              final_result = rem_fix;
      default:                      final_result = prod_fix[XLEN-1:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = direct_done ? DONE : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (count == CNT_W'(XLEN-1)) state_nxt = DONE;
      DONE:    if (flush || (out_valid && out_ready)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath registers are reset too, so a fresh unit never exposes stale operands or flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_MUL;
      tag_q      <= '0;
      count      <= '0;
      acc        <= '0;
      opnd       <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q  <= op_e'(in_op);
          tag_q <= in_tag;
          count <= '0;
          if (is_div) begin
            opnd  <= b_abs;
            q_neg <= neg_a ^ neg_b;
            r_neg <= neg_a;
            if (div_zero) begin
              acc   <= {in_a, {XLEN{1'b1}}};
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else if (div_ovf) begin
              acc   <= {{XLEN{1'b0}}, in_a};
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              acc <= {{XLEN{1'b0}}, a_abs};
            end
          end else begin
            opnd  <= a_abs;
            q_neg <= neg_a ^ neg_b;
            r_neg <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            acc   <= {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
`else
            acc   <= {{XLEN{1'b0}}, b_abs};
`endif
          end
        end
        CALC: begin
          acc   <= (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? div_next : mul_next;
          count <= count + 1'b1;
        end
        DONE: begin
          // First DONE cycle registers the corrected result; the handshake completes afterwards.
          if (!out_valid) begin
            out_result <= final_result;
            out_tag    <= tag_q;
            out_valid  <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32): directed corner cases, flush/reset scenarios and random ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycles from the accepting edge to the edge after which out_valid is high.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
    logic [31:0] exp_r;
    int          exp_lat, lat;
    exp_r   = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, out_result, exp_r);
    check({name, " tag"}, out_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " held valid"}, out_valid, 1'b1);
      check({name, " held result"}, out_result, exp_r);
      check({name, " held tag"}, out_tag, tag);
      check({name, " held in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " consumed valid"}, out_valid, 1'b0);
    check({name, " consumed in_ready"}, in_ready, 1'b1);
    check({name, " consumed busy"}, busy, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_r;
    logic        seen_valid;

    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset out_result", out_result, 32'h0);
    check("reset out_tag", out_tag, 5'h0);
    check("reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed corner cases.
    run_op("MUL 7*-3",       3'd0, 32'd7,          32'hFFFF_FFFD, 5'h03, 0);
    run_op("MULH min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'h04, 0);
    run_op("MULHU max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h05, 0);
    run_op("MULHSU -1*2",    3'd2, 32'hFFFF_FFFF, 32'd2,         5'h06, 0);
    run_op("DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'd2,         5'h07, 0);
    run_op("REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'd2,         5'h08, 0);
    run_op("DIVU 100/7",     3'd5, 32'd100,        32'd7,         5'h09, 5);
    run_op("REMU 100/7",     3'd7, 32'd100,        32'd7,         5'h0A, 0);
    run_op("DIVU 5/0",       3'd5, 32'd5,          32'd0,         5'h0B, 0);
    run_op("REM 5/0",        3'd6, 32'd5,          32'd0,         5'h0C, 0);
    run_op("DIV min/-1",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0D, 0);
    run_op("REM min/-1",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0E, 5);

    // Flush takes priority over an accept in the same cycle.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd50; in_b = 32'd5; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush-vs-accept busy", busy, 1'b0);
    check("flush-vs-accept in_ready", in_ready, 1'b1);

    // Flush ten cycles into an iterative op: the result must never appear.
    last_r = out_result;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush calc in_ready", in_ready, 1'b1);
    check("flush calc busy", busy, 1'b0);
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("flush calc no result", seen_valid, 1'b0);
    check("flush calc result kept", out_result, last_r);

    // Flush while a result waits in DONE, even with out_ready high.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd7; in_a = 32'd0; in_b = 32'd0; in_tag = 5'h12;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("flush done valid before", out_valid, 1'b1);
    check("flush done result before", out_result, 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush done valid", out_valid, 1'b0);
    check("flush done busy", busy, 1'b0);
    check("flush done result kept", out_result, 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'h13;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("reset mid busy", busy, 1'b0);
    check("reset mid out_valid", out_valid, 1'b0);
    check("reset mid out_result", out_result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("reset mid no result", seen_valid, 1'b0);
    run_op("DIVU 9/3 after reset", 3'd5, 32'd9, 32'd3, 5'h1A, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;
      r_op = 3'($urandom_range(0, 7));
      r_a  = pick_operand();
      r_b  = pick_operand();
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, 5'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
